// File: rtl/snn_io_pkg.sv
// Shared constants and types for the spiking-network result readout path.
package snn_io_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam logic [7:0]  STATUS_MAGIC = 8'hA5;
  localparam logic [7:0]  NO_WINNER    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ARGMAX,
    READY
  } state_e;

  function automatic int unsigned raster_words(input int unsigned steps,
                                               input int unsigned n_neur);
    return (steps * n_neur + WORD_W - 1) / WORD_W;
  endfunction

endpackage

// File: rtl/snn_result_tx_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/snn_result_tx.sv
// Captures an output spike raster plus per-neuron counts and a winner status,
// then serves them as 32-bit words on an iNEXT rising-edge handshake.
module snn_result_tx
  import snn_io_pkg::*;
#(
  parameter int N_NEUR = 2,
  parameter int STEPS  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iSTEP_VALID,
  input  logic [N_NEUR-1:0] iSPIKES,
  input  logic              iNEXT,
  output logic [31:0]       oWORD,
  output logic              oVALID,
  output logic              oLAST,
  output logic              oBUSY
);

  localparam int RW    = raster_words(STEPS, N_NEUR);
  localparam int TOTAL = RW + N_NEUR + 1;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int BITS  = RW * WORD_W;
  localparam int BIT_W = $clog2(BITS);

  state_e              state_q, state_d;
  logic [BITS-1:0]     raster_q, raster_d;
  logic [15:0]         step_q, step_d;
  logic [7:0]          aidx_q, aidx_d;
  logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic [7:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                prev_next_q, prev_next_d;

  logic [CNT_W-1:0]    cnt [N_NEUR];
  logic                cnt_clr;
  logic [N_NEUR-1:0]   cnt_inc;
  logic [CNT_W-1:0]    cur_cnt;
  logic [WORD_W-1:0]   word_sel;
  logic [BIT_W-1:0]    wr_base;
  logic                next_rise;

  for (genvar k = 0; k < N_NEUR; k++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (iCLK),
      .rst (iRESET),
      .clr (cnt_clr),
      .inc (cnt_inc[k]),
      .cnt (cnt[k])
    );
  end

  assign wr_base   = BIT_W'(step_q) * BIT_W'(N_NEUR);
  assign next_rise = iNEXT & ~prev_next_q;

  always_comb begin
    cur_cnt = '0;
    for (int unsigned k = 0; k < N_NEUR; k++)
      if (aidx_q == 8'(k)) cur_cnt = cnt[k];
  end

  always_comb begin
    state_d     = state_q;
    raster_d    = raster_q;
    step_d      = step_q;
    aidx_d      = aidx_q;
    best_cnt_d  = best_cnt_q;
    best_idx_d  = best_idx_q;
    word_idx_d  = word_idx_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    prev_next_d = iNEXT;
    cnt_clr     = 1'b0;
    cnt_inc     = '0;

    if (iSTART) begin
      state_d    = CAPTURE;
      raster_d   = '0;
      step_d     = '0;
      word_idx_d = '0;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      busy_d     = 1'b1;
      cnt_clr    = 1'b1;
    end else begin
      case (state_q)
        CAPTURE: if (iSTEP_VALID) begin
          raster_d[wr_base +: N_NEUR] = iSPIKES;
          cnt_inc = iSPIKES;
          step_d  = step_q + 16'd1;
          if (step_q == 16'(STEPS - 1)) begin
            state_d    = ARGMAX;
            aidx_d     = '0;
            best_cnt_d = '0;
            best_idx_d = NO_WINNER;
          end
        end
        ARGMAX: begin
          // Strict '>' from a zero baseline: ties keep the lower index, all-zero keeps NO_WINNER.
          if (cur_cnt > best_cnt_q) begin
            best_cnt_d = cur_cnt;
            best_idx_d = aidx_q;
          end
          aidx_d = aidx_q + 8'd1;
          if (aidx_q == 8'(N_NEUR - 1)) begin
            state_d    = READY;
            busy_d     = 1'b0;
            valid_d    = 1'b1;
            last_d     = 1'b0;
            word_idx_d = '0;
          end
        end
        READY: if (next_rise) begin
          if (word_idx_q == IDX_W'(TOTAL - 1)) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            word_idx_d = '0;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            last_d     = (word_idx_d == IDX_W'(TOTAL - 1));
          end
        end
        default: ;
      endcase
    end
  end

  // Output word is selected from the next index so it registers alongside oLAST.
  always_comb begin
    word_sel = '0;
    for (int unsigned w = 0; w < RW; w++)
      if (word_idx_d == IDX_W'(w)) word_sel = raster_q[w*WORD_W +: WORD_W];
    for (int unsigned k = 0; k < N_NEUR; k++)
      if (word_idx_d == IDX_W'(RW + k)) word_sel = WORD_W'(cnt[k]);
    if (word_idx_d == IDX_W'(TOTAL - 1))
      word_sel = {STATUS_MAGIC, best_idx_q, 16'(STEPS)};
    word_d = valid_d ? word_sel : '0;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= IDLE;
      raster_q    <= '0;
      step_q      <= '0;
      aidx_q      <= '0;
      best_cnt_q  <= '0;
      best_idx_q  <= '0;
      word_idx_q  <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      prev_next_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      raster_q    <= raster_d;
      step_q      <= step_d;
      aidx_q      <= aidx_d;
      best_cnt_q  <= best_cnt_d;
      best_idx_q  <= best_idx_d;
      word_idx_q  <= word_idx_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      prev_next_q <= prev_next_d;
    end
  end

  assign oWORD  = word_q;
  assign oVALID = valid_q;
  assign oLAST  = last_q;
  assign oBUSY  = busy_q;

endmodule

// File: tb/tb_snn_result_tx.sv
// Bench for snn_result_tx: default-width and 4-bit-counter instances share stimulus
// and are checked every cycle against a word-level model of the result.
module tb_snn_result_tx;

  localparam int N     = 2;
  localparam int STEPS = 64;
  localparam int RW    = (STEPS * N + 31) / 32;
  localparam int TOTAL = RW + N + 1;

  logic         clk = 1'b0;
  logic         rst, start, sv, nxt;
  logic [N-1:0] spikes;
  logic [31:0]  w1, w2;
  logic         v1, l1, b1, v2, l2, b2;

  int n_checks = 0;
  int n_err    = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  snn_result_tx #(.N_NEUR(N), .STEPS(STEPS), .CNT_W(16)) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start), .iSTEP_VALID(sv), .iSPIKES(spikes),
    .iNEXT(nxt), .oWORD(w1), .oVALID(v1), .oLAST(l1), .oBUSY(b1)
  );

  snn_result_tx #(.N_NEUR(N), .STEPS(STEPS), .CNT_W(4)) dut_sat (
    .iCLK(clk), .iRESET(rst), .iSTART(start), .iSTEP_VALID(sv), .iSPIKES(spikes),
    .iNEXT(nxt), .oWORD(w2), .oVALID(v2), .oLAST(l2), .oBUSY(b2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 capturing, 2 ranking, 3 serving.
  logic [N-1:0] m_spk [STEPS];
  int m_mode = 0, m_nstep = 0, m_wait = 0, m_idx = 0;
  bit m_prev = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_prev <= 1'b0; m_idx <= 0;
    end else begin
      m_prev <= nxt;
      if (start) begin
        m_mode <= 1; m_nstep <= 0;
      end else if (m_mode == 1) begin
        if (sv) begin
          m_spk[m_nstep] <= spikes;
          m_nstep <= m_nstep + 1;
          if (m_nstep == STEPS - 1) begin m_mode <= 2; m_wait <= N; end
        end
      end else if (m_mode == 2) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin m_mode <= 3; m_idx <= 0; end
      end else if (m_mode == 3) begin
        if (nxt && !m_prev) begin
          if (m_idx == TOTAL - 1) m_mode <= 0;
          else m_idx <= m_idx + 1;
        end
      end
    end
  end

  function automatic int model_count(input int k, input int cw);
    int sum = 0;
    int lim = (1 << cw) - 1;
    for (int s = 0; s < STEPS; s++) sum += int'(m_spk[s][k]);
    return (sum > lim) ? lim : sum;
  endfunction

  function automatic logic [31:0] model_word(input int idx, input int cw);
    logic [31:0] r = '0;
    int best = 0;
    logic [7:0] win = 8'hFF;
    if (idx < RW) begin
      for (int b = 0; b < 32; b++) begin
        int g = idx * 32 + b;
        if (g / N < STEPS) r[b] = m_spk[g / N][g % N];
      end
      return r;
    end
    if (idx < RW + N) return 32'(model_count(idx - RW, cw));
    for (int k = 0; k < N; k++)
      if (model_count(k, cw) > best) begin best = model_count(k, cw); win = 8'(k); end
    return {8'hA5, win, 16'(STEPS)};
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      logic ev, eb, el;
      ev = (m_mode == 3);
      eb = (m_mode == 1 || m_mode == 2);
      el = ev && (m_idx == TOTAL - 1);
      check("valid", 32'(v1), 32'(ev));
      check("busy",  32'(b1), 32'(eb));
      check("last",  32'(l1), 32'(el));
      check("word",  w1, ev ? model_word(m_idx, 16) : 32'h0);
      check("valid_sat", 32'(v2), 32'(ev));
      check("busy_sat",  32'(b2), 32'(eb));
      check("last_sat",  32'(l2), 32'(el));
      check("word_sat",  w2, ev ? model_word(m_idx, 4) : 32'h0);
    end
  end

  logic [31:0] r1 [TOTAL];
  logic [31:0] r2 [TOTAL];
  logic        rl [TOTAL];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [N-1:0] pattern(input int kind, input int s);
    case (kind)
      0: return 2'b01;
      1: return (s % 2 == 0) ? 2'b10 : 2'b00;
      2: return 2'b11;
      3: return 2'b00;
      4: return 2'b10;
      default: return N'($urandom);
    endcase
  endfunction

  task automatic capture(input int kind, input int nsteps, input bit gaps,
                         input bit do_start, input bit sv_with_start);
    if (do_start) begin
      start = 1'b1; sv = sv_with_start; spikes = 2'b11;
      tick();
      start = 1'b0; sv = 1'b0;
    end
    for (int s = 0; s < nsteps; s++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
          nxt = 1'($urandom); tick();
        end
      end
      spikes = pattern(kind, s); sv = 1'b1;
      tick();
      sv = 1'b0;
    end
    nxt = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!v1 && n < 200) begin tick(); n++; end
    check("ready_timeout", 32'(v1), 32'd1);
  endtask

  task automatic read_all(input bit jitter);
    int n;
    wait_valid(n);
    for (int i = 0; i < TOTAL; i++) begin
      r1[i] = w1; r2[i] = w2; rl[i] = l1;
      nxt = 1'b1; tick();
      nxt = 1'b0; tick();
      if (jitter) repeat ($urandom_range(0, 3)) tick();
    end
    check("valid_after_last", 32'(v1), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sv = 1'b0; nxt = 1'b0; spikes = '0;
    tick(); tick();
    armed = 1'b1;
    rst = 1'b0;

    // idle with iNEXT toggling
    for (int i = 0; i < 10; i++) begin nxt = ~nxt; tick(); end
    nxt = 1'b0;
    check("idle_word", w1, 32'h0);
    check("idle_valid", 32'(v1), 32'd0);

    // all 2'b01
    capture(0, STEPS, 1'b0, 1'b1, 1'b0);
    wait_valid(n);
    check("ready_latency_after_last_strobe", 32'(n + 1), 32'd3);
    read_all(1'b0);
    for (int i = 0; i < RW; i++) check("t2_raster", r1[i], 32'h5555_5555);
    check("t2_cnt0", r1[RW], 32'd64);
    check("t2_cnt1", r1[RW+1], 32'd0);
    check("t2_status", r1[TOTAL-1], 32'hA500_0040);
    check("t2_last_final", 32'(rl[TOTAL-1]), 32'd1);
    check("t2_last_early", 32'(rl[TOTAL-2]), 32'd0);
    check("t2_sat_cnt0", r2[RW], 32'd15);

    // even steps spike on neuron 1
    capture(1, STEPS, 1'b0, 1'b1, 1'b0);
    read_all(1'b0);
    check("t3_raster0", r1[0], 32'h2222_2222);
    check("t3_raster3", r1[RW-1], 32'h2222_2222);
    check("t3_cnt0", r1[RW], 32'd0);
    check("t3_cnt1", r1[RW+1], 32'd32);
    check("t3_status", r1[TOTAL-1], 32'hA501_0040);

    // tie, then all-zero
    capture(2, STEPS, 1'b0, 1'b1, 1'b0);
    read_all(1'b0);
    check("t4_raster", r1[1], 32'hFFFF_FFFF);
    check("t4_cnt1", r1[RW+1], 32'd64);
    check("t4_status_tie", r1[TOTAL-1], 32'hA500_0040);
    capture(3, STEPS, 1'b0, 1'b1, 1'b0);
    read_all(1'b0);
    check("t4_status_none", r1[TOTAL-1], 32'hA5FF_0040);

    // restart while serving word 2
    capture(0, STEPS, 1'b0, 1'b1, 1'b0);
    wait_valid(n);
    repeat (2) begin nxt = 1'b1; tick(); nxt = 1'b0; tick(); end
    start = 1'b1; tick(); start = 1'b0;
    check("t5_valid_drop", 32'(v1), 32'd0);
    check("t5_busy", 32'(b1), 32'd1);
    capture(4, STEPS, 1'b0, 1'b0, 1'b0);
    read_all(1'b0);
    check("t5_raster", r1[2], 32'hAAAA_AAAA);
    check("t5_cnt0", r1[RW], 32'd0);
    check("t5_cnt1", r1[RW+1], 32'd64);
    check("t5_status", r1[TOTAL-1], 32'hA501_0040);

    // iNEXT already high on entry to serving
    capture(0, STEPS - 1, 1'b0, 1'b1, 1'b0);
    nxt = 1'b1; spikes = 2'b01; sv = 1'b1; tick(); sv = 1'b0;
    wait_valid(n);
    repeat (5) tick();
    check("t6_word0_held", w1, 32'h5555_5555);
    check("t6_last_held", 32'(l1), 32'd0);
    nxt = 1'b0; tick();
    read_all(1'b0);
    check("t6_sat_cnt", r2[RW], 32'd15);
    check("t6_full_cnt", r1[RW], 32'd64);

    // reset mid-capture
    capture(2, 30, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", 32'(b1), 32'd0);
    check("rst_word", w1, 32'h0);
    capture(3, STEPS, 1'b0, 1'b1, 1'b0);
    read_all(1'b0);
    check("rst_clean_raster", r1[0], 32'h0);

    // randomized runs, including dropped strobes and aborted captures
    for (int r = 0; r < 8; r++) begin
      if (r == 3) capture(5, 20, 1'b1, 1'b1, 1'b1);
      capture(5, STEPS, 1'b1, 1'b1, 1'(r % 2));
      read_all(1'b1);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snn_result_tx.md
# snn_result_tx

Readout transmitter for the spiking-network result path, the host-bound counterpart of the JTAG image loader. It captures the per-timestep spike vector of the output neurons for one inference and packs the spike raster into 32-bit words. It also keeps a saturating spike count per neuron and a winner status word. The packed words go out one at a time on the same level/edge word handshake the host uses for image loading: `iNEXT` advances, `oLAST` marks the final word. It sits between the network's `neuron_out` and the JTAG read registers of the user design.

## Interface
Parameters:
- `N_NEUR`, 2: output neurons; must divide 32 and be ≤ 255.
- `STEPS`, 64: timesteps captured per inference; 1..65535.
- `CNT_W`, 16: spike counter width, ≤ 32.

Ports (one clock; reset is synchronous and active-high):
- `iCLK`  in  1  system clock (120 MHz main clock).
- `iRESET`  in  1  synchronous, active-high reset.
- `iSTART`  in  1  pulse: begin a new capture and discard any previous result.
- `iSTEP_VALID`  in  1  one-cycle strobe: `iSPIKES` holds one timestep.
- `iSPIKES`  in  N_NEUR  spike vector for the current timestep.
- `iNEXT`  in  1  host level; each rising edge requests the next word.
- `oWORD`  out  32  current output word.
- `oVALID`  out  1  `oWORD` is a valid result word.
- `oLAST`  out  1  `oWORD` is the final word of the result.
- `oBUSY`  out  1  capture or argmax in progress.

## Operation
- Derived values: RW = ceil(STEPS·N_NEUR/32) raster words; TOTAL = RW + N_NEUR + 1.
- Word map:
  - Words 0..RW-1: raster. Step s, neuron n sits at global bit s·N_NEUR+n; word = bit/32, LSB first. Unused bits are 0.
  - Words RW..RW+N_NEUR-1: count of neuron k, zero-extended.
  - Word TOTAL-1: status `{8'hA5, winner[7:0], STEPS[15:0]}`.
- Counters saturate at 2^CNT_W−1.
- Winner is the index of the maximum count; ties go to the lowest index. If all counts are 0, winner = 8'hFF.
- States:
  - IDLE. `iSTART` → CAPTURE.
  - CAPTURE. Clears the raster, counters and step index on entry. Each `iSTEP_VALID` stores `iSPIKES` and increments the counts. The STEPS-th strobe → ARGMAX.
  - ARGMAX. Sequential compare, one neuron per cycle, N_NEUR cycles → READY.
  - READY. Word index = 0, `oVALID` = 1. Each detected `iNEXT` rising edge advances the index. A rising edge while on word TOTAL-1 → IDLE.
- `iSTART` in any state restarts into CAPTURE; partially read results are lost.
- `iSTEP_VALID` outside CAPTURE is ignored. `iNEXT` edges outside READY are ignored.
- The edge detector (previous `iNEXT` register) updates every cycle in all states. A level already high when READY is entered does not advance the index.

## Timing
- Reset values: `oWORD` = 0, `oVALID` = 0, `oLAST` = 0, `oBUSY` = 0, state IDLE, previous-`iNEXT` register = 0.
- Capture start: `iSTART` at cycle t → CAPTURE at t+1, `oBUSY` = 1 from t+1. The first strobe accepted is at t+1.
- Result ready: the STEPS-th strobe at cycle c → `oBUSY` = 0 and `oVALID` = 1 with word 0 at c+N_NEUR+1.
- Word advance: `iNEXT` = 1 at cycle t with previous = 0 → `oWORD` shows the next word at t+1. `oLAST` is registered alongside `oWORD`.
- After the last word: rising edge on word TOTAL-1 at t → `oVALID` = 0, `oLAST` = 0, `oWORD` = 0 at t+1.
- `iSTART` while READY at t → `oVALID` = 0 at t+1.
- `iSTART` and `iSTEP_VALID` in the same cycle: `iSTART` wins and the strobe is dropped.
- Reset has priority over everything; reset mid-capture returns to IDLE with all buffers cleared.

## Structure
- Package `snn_io_pkg`:
  - word width 32;
  - status magic 8'hA5;
  - no-winner code 8'hFF;
  - state enum {IDLE, CAPTURE, ARGMAX, READY};
  - function for RW.
- One sub-module, `sat_counter`: CNT_W-bit saturating counter with synchronous clear and increment enable. Instantiate it N_NEUR times.
- The raster is a flat RW·32 register array, written at bit index step·N_NEUR. No RAM inference.

## Test plan
1. Reset, then hold idle with `iNEXT` toggling → `oVALID`/`oLAST`/`oBUSY` stay 0 and `oWORD` stays 0.
2. `iSTART`, 64 strobes of 2'b01 → words 0–3 = 32'h5555_5555, word4 = 64, word5 = 0, word6 = 32'hA500_0040. `oLAST` is high only with word6. `oVALID` rises exactly 3 cycles after the last strobe.
3. 64 strobes alternating 2'b10/2'b00 (even steps spike) → raster words = 32'h2222_2222, counts 0 and 32, status 32'hA501_0040.
4. 64 strobes of 2'b11 → raster words = 32'hFFFF_FFFF, counts 64/64, winner 0 (tie). Then 64 strobes of 2'b00 → winner 8'hFF.
5. `iSTART` while on word 2 → `oVALID` = 0 next cycle, `oBUSY` = 1. The new capture of 2'b10 ×64 yields clean words with no residue from the previous run.
6. `iNEXT` held high across READY entry → word 0 held until a low-then-high edge. With CNT_W = 4 and 64 strobes of 2'b01 → count word = 15 (saturated).
